// File: rtl/lif_seq_ctrl.sv
// lif_seq_ctrl: timestep sequencer for a leaky integrate-and-fire neuron.
// Each timestep clears the accumulator, scans FANIN synaptic addresses and
// waits one cycle for read latency. It then strobes the neuron update.
// While idle it writes weights into the synaptic memory.
// All strobes and status outputs come straight from flops.
module lif_seq_ctrl #(
   parameter int  FANIN        = 256,
   parameter int  WT_PRECISION = 5,
   localparam int ADDR_WIDTH   = $clog2(FANIN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic                    cfg_req,
   input  logic [ADDR_WIDTH-1:0]   cfg_addr,
   input  logic [WT_PRECISION-1:0] cfg_data,
   output logic                    cfg_ack,
   output logic                    wr_en,
   output logic [ADDR_WIDTH-1:0]   wr_addr,
   output logic [WT_PRECISION-1:0] wr_data,
   output logic                    rd_en,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic                    rst_acc,
   output logic                    spk_en,
   output logic                    busy,
   output logic                    done,
   output logic                    overrun,
   output logic [15:0]             ts_count
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_SCAN  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_FIRE  = 3'd4;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FANIN - 1);

   logic [2:0]              state_q, state_d;
   logic                    pend_start_q, pend_start_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [15:0]             ts_count_q, ts_count_d;
   logic                    overrun_q, overrun_d;
   logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic [WT_PRECISION-1:0] wr_data_q, wr_data_d;
   logic                    wr_take;
   logic                    start_pend;
   logic                    rst_acc_q, rst_acc_d;
   logic                    rd_en_q, rd_en_d;
   logic                    wr_en_q, wr_en_d;
   logic                    cfg_ack_q, cfg_ack_d;
   logic                    spk_en_q, spk_en_d;
   logic                    done_q, done_d;
   logic                    busy_q, busy_d;

   // Next-state, counters and registered-output decode
   always_comb begin
      state_d      = state_q;
      pend_start_d = pend_start_q;
      addr_d       = addr_q;
      ts_count_d   = ts_count_q;
      overrun_d    = overrun_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      wr_take      = 1'b0;
      // A start that coincides with abort is dropped; only IDLE can accept one.
      start_pend   = pend_start_q | (start & ~abort);

      // A start arriving while a timestep is running is lost and flagged.
      if (state_q != S_IDLE && start) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (cfg_req) begin
               // A weight write wins; any start waits in pend_start.
               wr_take      = 1'b1;
               wr_addr_d    = cfg_addr;
               wr_data_d    = cfg_data;
               pend_start_d = start_pend;
            end else if (start_pend) begin
               state_d      = S_CLEAR;
               pend_start_d = 1'b0;
            end
         end
         S_CLEAR: begin
            pend_start_d = 1'b0;
            addr_d       = '0;
            state_d      = abort ? S_IDLE : S_SCAN;
         end
         S_SCAN: begin
            if (abort) begin
               state_d      = S_IDLE;
               addr_d       = '0;
               pend_start_d = 1'b0;
            end else if (addr_q == LAST_ADDR) begin
               state_d = S_DRAIN;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + ADDR_WIDTH'(1);
            end
         end
         S_DRAIN: begin
            if (abort) begin
               state_d      = S_IDLE;
               pend_start_d = 1'b0;
            end else begin
               // The count steps as FIRE is entered so done and the new count coincide.
               state_d    = S_FIRE;
               ts_count_d = ts_count_q + 16'd1;
            end
         end
         S_FIRE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      rst_acc_d = (state_d == S_CLEAR);
      rd_en_d   = (state_d == S_SCAN);
      spk_en_d  = (state_d == S_FIRE);
      done_d    = (state_d == S_FIRE);
      busy_d    = (state_d != S_IDLE);
      wr_en_d   = wr_take;
      cfg_ack_d = wr_take;
   end

   // State, counters and output flops with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         pend_start_q <= 1'b0;
         addr_q       <= '0;
         ts_count_q   <= 16'd0;
         overrun_q    <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         rst_acc_q    <= 1'b0;
         rd_en_q      <= 1'b0;
         wr_en_q      <= 1'b0;
         cfg_ack_q    <= 1'b0;
         spk_en_q     <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_start_q <= pend_start_d;
         addr_q       <= addr_d;
         ts_count_q   <= ts_count_d;
         overrun_q    <= overrun_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         rst_acc_q    <= rst_acc_d;
         rd_en_q      <= rd_en_d;
         wr_en_q      <= wr_en_d;
         cfg_ack_q    <= cfg_ack_d;
         spk_en_q     <= spk_en_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
      end
   end

   assign cfg_ack  = cfg_ack_q;
   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign rd_en    = rd_en_q;
   assign rd_addr  = addr_q;
   assign rst_acc  = rst_acc_q;
   assign spk_en   = spk_en_q;
   assign done     = done_q;
   assign busy     = busy_q;
   assign overrun  = overrun_q;
   assign ts_count = ts_count_q;

endmodule
